// File: rtl/riscv_defines.sv
// Shared definitions for the instruction-port arbiter slice: requester IDs
// used as owner tags for outstanding instruction fetches.
package riscv_defines;

  typedef logic [0:0] arb_port_t;

  localparam arb_port_t ARB_PORT_IF  = 1'b0;
  localparam arb_port_t ARB_PORT_AUX = 1'b1;

endpackage

// File: rtl/riscv_arb_tag_fifo.sv
// Owner-tag FIFO: remembers which requester issued each granted fetch so the
// matching response can be steered back in order.
module riscv_arb_tag_fifo
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  arb_port_t wdata,
  output arb_port_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  arb_port_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= ARB_PORT_IF;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_en) rd_ptr <= next_ptr(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Shares one instruction-memory port between the IF prefetcher (port 0) and an
// auxiliary reader (port 1). Optional perf counters: define INSTR_ARB_PERF_EN.
module riscv_instr_port_arbiter
  import riscv_defines::*;
#(
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PORT0_PRIO      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_i,
  input  logic [1:0][31:0]       addr_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [RDATA_WIDTH-1:0] rdata_o,
  output logic                   err_pmp_o,
  output logic                   instr_req_o,
  output logic [31:0]            instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
  input  logic                   instr_err_pmp_i,
  output logic                   busy_o,
  output logic                   protocol_err_o
`ifdef INSTR_ARB_PERF_EN
  ,
  output logic [31:0]            conflict_cnt_o,
  output logic [31:0]            full_stall_cnt_o
`endif
);

  arb_port_t sel;
  arb_port_t sel_q;
  arb_port_t rr_ptr;
  arb_port_t head;
  logic      lock_q;
  logic      fifo_full;
  logic      fifo_empty;
  logic      handshake;
  logic      rsp_ok;

  // A pending ungranted request keeps its port so req/addr stay stable.
  always_comb begin
    if (lock_q)                sel = sel_q;
    else if (req_i == 2'b11)   sel = (PORT0_PRIO != 0) ? ARB_PORT_IF : rr_ptr;
    else if (req_i[1])         sel = ARB_PORT_AUX;
    else                       sel = ARB_PORT_IF;
  end

  // fifo_full comes from registered state, so no gnt-to-req loop exists.
  assign instr_req_o  = req_i[sel] & ~fifo_full;
  assign instr_addr_o = addr_i[sel];
  assign handshake    = instr_req_o & instr_gnt_i;
  assign rsp_ok       = instr_rvalid_i & ~fifo_empty;

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = handshake;
  end

  always_comb begin
    rvalid_o       = '0;
    rvalid_o[head] = rsp_ok;
  end

  assign rdata_o   = instr_rdata_i;
  assign err_pmp_o = instr_err_pmp_i;
  assign busy_o    = ~fifo_empty | (|req_i);

  riscv_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (handshake),
    .pop   (instr_rvalid_i),
    .wdata (sel),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q         <= 1'b0;
      sel_q          <= ARB_PORT_IF;
      rr_ptr         <= ARB_PORT_IF;
      protocol_err_o <= 1'b0;
    end else begin
      lock_q <= instr_req_o & ~instr_gnt_i;
      sel_q  <= sel;
      if (handshake) rr_ptr <= ~sel;
      if (instr_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
    end
  end

`ifdef INSTR_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_o   <= '0;
      full_stall_cnt_o <= '0;
    end else begin
      if ((req_i == 2'b11) && !gnt_o[0] && (conflict_cnt_o != '1))
        conflict_cnt_o <= conflict_cnt_o + 1'b1;
      if (req_i[sel] && fifo_full && (full_stall_cnt_o != '1))
        full_stall_cnt_o <= full_stall_cnt_o + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Dropping req_i while the arbiter is locked on that port is a requester bug.
  locked_req_held : assert property (@(posedge clk) disable iff (!rst_n)
                                     lock_q |-> req_i[sel_q]);
`endif

endmodule
